// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the horizontal phase type,
// used by the horizontal and vertical counters.
package vga_pkg;

    typedef enum logic [1:0] {
        PhActive = 2'd0,
        PhFront  = 2'd1,
        PhSync   = 2'd2,
        PhBack   = 2'd3
    } h_phase_t;

    localparam int unsigned HCountW = 10;

    localparam int unsigned HActive = 640;
    localparam int unsigned HFp     = 16;
    localparam int unsigned HSync   = 96;
    localparam int unsigned HBp     = 48;
    localparam int unsigned HTotal  = HActive + HFp + HSync + HBp;

    localparam int unsigned VActive = 480;
    localparam int unsigned VFp     = 10;
    localparam int unsigned VSync   = 2;
    localparam int unsigned VBp     = 33;
    localparam int unsigned VTotal  = VActive + VFp + VSync + VBp;

endpackage

// File: rtl/h_counter_if.sv
// Horizontal timing bus from h_counter to its consumers (vertical counter, pixel logic).
// With H_COUNTER_HOLD_EN defined the consumer side also drives h_hold.
interface h_counter_if;
    import vga_pkg::*;

    logic [HCountW-1:0] h_count;
    logic               pix_tick;
    logic               enable_v;
    logic               hsync;
    logic               h_video_on;
    h_phase_t           h_phase;
`ifdef H_COUNTER_HOLD_EN
    logic               h_hold;

    modport master (
        output h_count, pix_tick, enable_v, hsync, h_video_on, h_phase,
        input  h_hold
    );
    modport slave (
        input  h_count, pix_tick, enable_v, hsync, h_video_on, h_phase,
        output h_hold
    );
`else
    modport master (
        output h_count, pix_tick, enable_v, hsync, h_video_on, h_phase
    );
    modport slave (
        input  h_count, pix_tick, enable_v, hsync, h_video_on, h_phase
    );
`endif
endinterface

// File: rtl/pix_clk_div.sv
// Divides clk by CLK_DIV (1..16) into a registered one-clk pix_tick; 'advance' is the
// combinational same-cycle strobe used by pixel-rate state that updates with pix_tick.
module pix_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    output logic advance,
    output logic pix_tick
);
    localparam int unsigned   DivW    = 4;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;

    always_comb begin
        advance = ~stall && (div_q == DivLast);
        div_d   = div_q;
        if (!stall) begin
            div_d = advance ? '0 : div_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            pix_tick <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_tick <= advance;
        end
    end

endmodule

// File: rtl/h_counter.sv
// Horizontal VGA timing: pixel counter, phase FSM, registered hsync/h_video_on and the
// per-line enable_v pulse. Optional freeze input h_hold under H_COUNTER_HOLD_EN.
module h_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = HActive,
    parameter int unsigned H_FP         = HFp,
    parameter int unsigned H_SYNC       = HSync,
    parameter int unsigned H_BP         = HBp,
    parameter int unsigned CLK_DIV      = 4,
    parameter logic        HSYNC_ACTIVE = 1'b0
) (
    input logic         clk,
    input logic         reset,
    h_counter_if.master bus
);
    localparam logic [HCountW-1:0] LastPix    = HCountW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [HCountW-1:0] FrontStart = HCountW'(H_ACTIVE);
    localparam logic [HCountW-1:0] SyncStart  = HCountW'(H_ACTIVE + H_FP);
    localparam logic [HCountW-1:0] BackStart  = HCountW'(H_ACTIVE + H_FP + H_SYNC);

    logic stall;
    logic advance;
    logic pix_tick;

`ifdef H_COUNTER_HOLD_EN
    assign stall = bus.h_hold;
`else
    assign stall = 1'b0;
`endif

    pix_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_clk_div (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .advance (advance),
        .pix_tick(pix_tick)
    );

    logic [HCountW-1:0] count_q, count_d;
    h_phase_t           phase_q, phase_d;
    logic               enable_v_q, enable_v_d;
    logic               hsync_q, hsync_d;
    logic               video_q, video_d;

    // Phase and derived outputs are computed from the next count so they stay
    // aligned with h_count after the edge.
    always_comb begin
        count_d    = count_q;
        phase_d    = phase_q;
        enable_v_d = 1'b0;
        if (advance) begin
            if (count_q == LastPix) begin
                count_d    = '0;
                enable_v_d = 1'b1;
            end else begin
                count_d = count_q + 10'd1;
            end
            if (count_d == FrontStart) begin
                phase_d = PhFront;
            end else if (count_d == SyncStart) begin
                phase_d = PhSync;
            end else if (count_d == BackStart) begin
                phase_d = PhBack;
            end else if (count_d == '0) begin
                phase_d = PhActive;
            end
        end
        hsync_d = (phase_d == PhSync) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
        video_d = (phase_d == PhActive);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            phase_q    <= PhActive;
            enable_v_q <= 1'b0;
            hsync_q    <= ~HSYNC_ACTIVE;
            video_q    <= 1'b1;
        end else begin
            count_q    <= count_d;
            phase_q    <= phase_d;
            enable_v_q <= enable_v_d;
            hsync_q    <= hsync_d;
            video_q    <= video_d;
        end
    end

    assign bus.h_count    = count_q;
    assign bus.pix_tick   = pix_tick;
    assign bus.enable_v   = enable_v_q;
    assign bus.hsync      = hsync_q;
    assign bus.h_video_on = video_q;
    assign bus.h_phase    = phase_q;

endmodule

// File: tb/tb_h_counter.sv
// Bench for h_counter: CLK_DIV=4 and CLK_DIV=1 instances checked every clk against an
// arithmetic model of pixel position, plus line-length and async-reset checks.
module tb_h_counter;

    logic clk;
    logic reset;
    logic hold;
    logic measure_en;

    int checks = 0;
    int errors = 0;

    // Model state: n = clk edges since reset that were not held.
    int unsigned n = 0;
    bit          held = 1'b0;

    int cyc = 0;
    int last4 = -1;
    int last1 = -1;
    int lo_cnt = 0;

    h_counter_if bus4 ();
    h_counter_if bus1 ();

`ifdef H_COUNTER_HOLD_EN
    assign bus4.h_hold = hold;
    assign bus1.h_hold = hold;
`endif

    h_counter #(.CLK_DIV(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
    h_counter #(.CLK_DIV(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_inst(input string nm, input int unsigned d, input logic [9:0] hc,
                              input logic pt, input logic ev, input logic hs,
                              input logic vo, input logic [1:0] ph);
        int unsigned p;
        bit          tick;
        int unsigned phase;
        p     = (n / d) % 800;
        tick  = !held && (n > 0) && ((n % d) == 0);
        phase = (p < 640) ? 0 : (p < 656) ? 1 : (p < 752) ? 2 : 3;
        check({nm, ".h_count"},    32'(hc), p);
        check({nm, ".pix_tick"},   32'(pt), 32'(tick));
        check({nm, ".enable_v"},   32'(ev), 32'(tick && (p == 0)));
        check({nm, ".hsync"},      32'(hs), 32'(!(p >= 656 && p < 752)));
        check({nm, ".h_video_on"}, 32'(vo), 32'(p < 640));
        check({nm, ".h_phase"},    32'(ph), phase);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n    <= 0;
            held <= 1'b0;
        end else begin
            held <= hold;
            if (!hold) n <= n + 1;
        end
    end

    always @(negedge clk) begin
        check_inst("d4", 4, bus4.h_count, bus4.pix_tick, bus4.enable_v, bus4.hsync,
                   bus4.h_video_on, bus4.h_phase);
        check_inst("d1", 1, bus1.h_count, bus1.pix_tick, bus1.enable_v, bus1.hsync,
                   bus1.h_video_on, bus1.h_phase);
        cyc <= cyc + 1;
        if (reset || !measure_en) begin
            last4  <= -1;
            last1  <= -1;
            lo_cnt <= 0;
        end else begin
            if (bus4.enable_v) begin
                if (last4 >= 0) begin
                    check("d4.line_clks", 32'(cyc - last4), 3200);
                    check("d4.hsync_low_clks", 32'(lo_cnt), 384);
                end
                last4  <= cyc;
                lo_cnt <= 0;
            end else if (!bus4.hsync) begin
                lo_cnt <= lo_cnt + 1;
            end
            if (bus1.enable_v) begin
                if (last1 >= 0) check("d1.line_clks", 32'(cyc - last1), 800);
                last1 <= cyc;
            end
        end
    end

    initial begin
        bit found;
        reset      = 1'b1;
        hold       = 1'b0;
        measure_en = 1'b0;
        repeat (3) @(negedge clk);
        reset      = 1'b0;
        measure_en = 1'b1;
        repeat (3 * 3200 + 100) @(negedge clk);
        measure_en = 1'b0;

        // Reset in the middle of the sync phase must clear outputs without a clock edge.
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (bus4.h_count == 10'd700) found = 1'b1;
        end
        check("wait_h700", 32'(found), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("async.h_count",    32'(bus4.h_count), 0);
        check("async.hsync",      32'(bus4.hsync), 1);
        check("async.h_video_on", 32'(bus4.h_video_on), 1);
        check("async.enable_v",   32'(bus4.enable_v), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset      = 1'b0;
        measure_en = 1'b1;
        repeat (2 * 3200 + 50) @(negedge clk);
        measure_en = 1'b0;

`ifdef H_COUNTER_HOLD_EN
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (bus4.h_count == 10'd799) found = 1'b1;
        end
        check("wait_h799", 32'(found), 1);
        hold = 1'b1;
        repeat (10) @(negedge clk);
        hold = 1'b0;
        repeat (100) @(negedge clk);
`endif

        // Random run lengths, random mid-line resets and (when enabled) random holds.
        for (int it = 0; it < 6; it++) begin
            int unsigned len;
            len = $urandom_range(2500, 50);
            for (int c = 0; c < int'(len); c++) begin
                @(negedge clk);
`ifdef H_COUNTER_HOLD_EN
                if ($urandom_range(199, 0) == 0) hold = ~hold;
`endif
            end
            hold  = 1'b0;
            reset = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            reset = 1'b0;
        end
        repeat (3300) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/h_counter.md
Name: h_counter

Overview:
- Horizontal timing stage for the VGA 640x480@60 path; sits directly upstream of the vertical line counter.
- Divides the system clock down to a pixel tick and counts pixels 0..799 per line.
- Tracks the horizontal phase (active, front porch, sync, back porch) and produces hsync and a horizontal video-active flag.
- Emits enable_v as a single-clk pulse once per line, which advances the vertical counter.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, front-porch pixels
- H_SYNC, 96, sync-pulse pixels
- H_BP, 48, back-porch pixels
- CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz); legal range 1..16
- HSYNC_ACTIVE, 0, hsync level while in the sync phase (0 = active-low)

Ports:
- clk  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-high reset
- h_count  out  10  current pixel index, 0..H_TOTAL-1
- pix_tick  out  1  one-clk pulse marking a pixel advance
- enable_v  out  1  one-clk pulse per line; drives the vertical counter's enable
- hsync  out  1  horizontal sync, polarity set by HSYNC_ACTIVE
- h_video_on  out  1  high while h_count is in the active region
- h_phase  out  2  0=ACTIVE, 1=FRONT, 2=SYNC, 3=BACK

Behaviour:
- Timing arithmetic
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800 by default); all compares are 10-bit unsigned.
- Reset (async assert; takes effect on the first posedge after deassert)
  - div=0, h_count=0, phase=ACTIVE, pix_tick=0, enable_v=0, hsync=~HSYNC_ACTIVE, h_video_on=1.
- Divider
  - div counts 0..CLK_DIV-1 and wraps to 0.
  - pix_tick is registered and is high for exactly one clk when div == CLK_DIV-1.
  - With CLK_DIV=1, pix_tick is high every clk after reset.
- Counter
  - On a clk where div == CLK_DIV-1: h_count increments; at H_TOTAL-1 it wraps to 0.
  - h_count updates in the same clk that pix_tick is high.
- enable_v
  - Registered; high for exactly one clk, coincident with the pix_tick in which h_count becomes 0.
  - Never high for more than one consecutive clk, regardless of CLK_DIV, because the vertical counter increments on every clk its enable is high.
- Phase FSM (advances only on pixel advance)
  - ACTIVE -> FRONT when h_count goes H_ACTIVE-1 -> H_ACTIVE.
  - FRONT -> SYNC at H_ACTIVE+H_FP.
  - SYNC -> BACK at H_ACTIVE+H_FP+H_SYNC.
  - BACK -> ACTIVE on the wrap to 0.
  - Default values: FRONT 640..655, SYNC 656..751, BACK 752..799.
- Derived outputs
  - hsync = HSYNC_ACTIVE when phase==SYNC, otherwise its inverse; registered and aligned with h_count.
  - h_video_on = (phase==ACTIVE); registered and aligned with h_count.
  - Combinational decode of h_count is forbidden; outputs change only on posedge or reset.
- Reset mid-line
  - All state returns to the reset values immediately; no enable_v pulse is generated by reset.

Optional Feature:
- Macro H_COUNTER_HOLD_EN.
- Defined:
  - Adds input h_hold (1 bit).
  - While h_hold=1, div, h_count and phase freeze; pix_tick and enable_v are forced to 0; hsync and h_video_on hold their values.
  - When h_hold falls, counting resumes from the frozen state, with no skipped or repeated pixels.
- Undefined: the port is absent and counting is free-running.

Decomposition:
- Shared package vga_pkg holds:
  - h_phase_t enum (ACTIVE, FRONT, SYNC, BACK)
  - the default 640x480 horizontal and vertical timing constants, including V_TOTAL=525, shared with the vertical counter
- Natural sub-module: pix_clk_div (divider plus pix_tick), reusable by other pixel-rate blocks.

Test Plan:
- Reset release, defaults: h_count=0, hsync=1, h_video_on=1; first pix_tick 4 clks after release; h_count=1 after 4 clks.
- Full line, CLK_DIV=4: exactly 3200 clks between enable_v pulses; each pulse is 1 clk wide and coincides with h_count=0.
- Phase edges:
  - hsync low exactly for h_count 656..751 (96 pixels, 384 clks).
  - h_video_on low exactly for h_count 640..799.
  - h_phase sequence 0,1,2,3 at 640/656/752/0.
- CLK_DIV=1: pix_tick constantly 1; enable_v every 800 clks and still 1 clk wide; wrap 799->0.
- Reset asserted at h_count=700 (SYNC) for 2 clks: outputs return to reset values asynchronously; no spurious enable_v; the next line is a full 800 pixels.
- With H_COUNTER_HOLD_EN: hold asserted for 10 clks at h_count=799 delays the wrap and enable_v by exactly 10 clks; no duplicate pulse.
